bus_timer: RTL and testbench

BUS_TIMER -- requirements
Module: bus_timer

---
 rtl/bus_timer_if.sv | 13 +
 rtl/bus_timer.sv | 120 ++++++++++++
 tb/tb_bus_timer.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_timer_if.sv
// CPU-side register bus for bus_timer: word-select, write strobe with byte enables,
// combinational read data and the interrupt request.
interface bus_timer_if;
   logic [1:0]  addr;
   logic        we;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        irq;

   modport master (output addr, we, be, wdata, input rdata, irq);
   modport slave  (input addr, we, be, wdata, output rdata, irq);
endinterface

// File: rtl/bus_timer.sv
// Memory-mapped down-counter with one-shot / auto-reload modes and a maskable interrupt.
// Optional macro BUS_TIMER_BE_EN: honour byte enables on writes (otherwise full-word writes).
module bus_timer (
   input  logic   clk,
   input  logic   reset,
   bus_timer_if.slave bus
);

   typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_e;

   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_PRESET = 2'd1;
   localparam logic [1:0] ADDR_COUNT  = 2'd2;
   localparam logic [1:0] MODE_RELOAD = 2'b01;

   state_e      state_q, state_d;
   logic [3:0]  ctrl_q, ctrl_d;       // {IM, MODE[1:0], EN}
   logic [31:0] preset_q, preset_d;
   logic [31:0] count_q, count_d;
   logic        irq_flag_q, irq_flag_d;

   logic [31:0] wmask;
   logic        ctrl_wr;
   logic        preset_wr;
   logic        en;
   logic [1:0]  mode;

`ifdef BUS_TIMER_BE_EN
   assign wmask = {{8{bus.be[3]}}, {8{bus.be[2]}}, {8{bus.be[1]}}, {8{bus.be[0]}}};
`else
   assign wmask = 32'hFFFF_FFFF;
`endif

   assign ctrl_wr   = bus.we && (bus.addr == ADDR_CTRL);
   assign preset_wr = bus.we && (bus.addr == ADDR_PRESET);
   assign en        = ctrl_q[0];
   assign mode      = ctrl_q[2:1];

   always_comb begin
      ctrl_d     = ctrl_q;
      preset_d   = preset_q;
      count_d    = count_q;
      state_d    = state_q;
      irq_flag_d = irq_flag_q;

      if (ctrl_wr) begin
         ctrl_d = (ctrl_q & ~wmask[3:0]) | (bus.wdata[3:0] & wmask[3:0]);
      end
      if (preset_wr) begin
         preset_d = (preset_q & ~wmask) | (bus.wdata & wmask);
      end

      // Auto-reload gives a one-cycle pulse; one-shot holds until the CPU touches CTRL.
      if (mode == MODE_RELOAD) begin
         irq_flag_d = 1'b0;
      end else if (ctrl_wr) begin
         irq_flag_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (en) state_d = LOAD;
         end
         LOAD: begin
            count_d = preset_q;
            state_d = CNT;
         end
         CNT: begin
            if (!en) begin
               state_d = IDLE;
            end else if (count_q > 32'd1) begin
               count_d = count_q - 32'd1;
            end else begin
               count_d = 32'd0;
               state_d = INT;
            end
         end
         INT: begin
            irq_flag_d = 1'b1;
            if (mode == MODE_RELOAD) begin
               state_d = LOAD;
            end else begin
               state_d = IDLE;
               // A same-cycle CPU write to CTRL takes precedence over the EN clear.
               if (!ctrl_wr) ctrl_d[0] = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= IDLE;
         ctrl_q     <= 4'd0;
         preset_q   <= 32'd0;
         count_q    <= 32'd0;
         irq_flag_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ctrl_q     <= ctrl_d;
         preset_q   <= preset_d;
         count_q    <= count_d;
         irq_flag_q <= irq_flag_d;
      end
   end

   always_comb begin
      bus.rdata = 32'd0;
      case (bus.addr)
         ADDR_CTRL:   bus.rdata = {28'd0, ctrl_q};
         ADDR_PRESET: bus.rdata = preset_q;
         ADDR_COUNT:  bus.rdata = count_q;
         default:     bus.rdata = 32'd0;
      endcase
   end

   assign bus.irq = irq_flag_q & ctrl_q[3];

endmodule

// File: tb/tb_bus_timer.sv
// Self-checking bench for bus_timer: register access vector table plus
// hand-written timer sequences; expectations flow through a scoreboard queue.
module tb_bus_timer;

   logic clk = 1'b0;
   logic reset;

   bus_timer_if bus ();

   bus_timer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] exp_q[$];

   typedef struct {
      logic [1:0]  addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic        exp_irq;
   } vec_t;

   vec_t vecs[18];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic compare(input string name, input logic [31:0] act);
      logic [31:0] e;
      n_checks++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL %s: got %08h, no expected value queued", name, act);
      end else begin
         e = exp_q.pop_front();
         if (act !== e) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, e);
         end
      end
   endtask

   task automatic check_rd(input logic [1:0] a, input logic [31:0] e, input string name);
      exp_q.push_back(e);
      bus.addr = a;
      #1;
      compare(name, bus.rdata);
   endtask

   task automatic check_irq(input logic e, input string name);
      exp_q.push_back({31'd0, e});
      compare(name, {31'd0, bus.irq});
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] b);
      bus.addr  = a;
      bus.wdata = d;
      bus.be    = b;
      bus.we    = 1'b1;
      tick();
      bus.we    = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   initial begin
      logic [31:0] be_exp;
      logic [31:0] exp_cnt;
      int ph;

      reset     = 1'b0;
      bus.addr  = 2'd0;
      bus.we    = 1'b0;
      bus.be    = 4'hF;
      bus.wdata = 32'd0;

`ifdef BUS_TIMER_BE_EN
      be_exp = 32'hAA22_CCDD;
`else
      be_exp = 32'h1122_3344;
`endif

      // {addr, we, be, wdata, rdata seen before this write lands, irq}
      vecs[0]  = '{2'd0, 1'b0, 4'hF, 32'h0000_0000, 32'h0000_0000, 1'b0};
      vecs[1]  = '{2'd1, 1'b0, 4'hF, 32'h0000_0000, 32'h0000_0000, 1'b0};
      vecs[2]  = '{2'd2, 1'b0, 4'hF, 32'h0000_0000, 32'h0000_0000, 1'b0};
      vecs[3]  = '{2'd3, 1'b0, 4'hF, 32'h0000_0000, 32'h0000_0000, 1'b0};
      vecs[4]  = '{2'd0, 1'b1, 4'hF, 32'hFFFF_FFF6, 32'h0000_0000, 1'b0};
      vecs[5]  = '{2'd0, 1'b0, 4'hF, 32'h0000_0000, 32'h0000_0006, 1'b0};
      vecs[6]  = '{2'd1, 1'b1, 4'hF, 32'h1234_5678, 32'h0000_0000, 1'b0};
      vecs[7]  = '{2'd1, 1'b0, 4'hF, 32'h0000_0000, 32'h1234_5678, 1'b0};
      vecs[8]  = '{2'd2, 1'b1, 4'hF, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
      vecs[9]  = '{2'd2, 1'b0, 4'hF, 32'h0000_0000, 32'h0000_0000, 1'b0};
      vecs[10] = '{2'd3, 1'b1, 4'hF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
      vecs[11] = '{2'd3, 1'b0, 4'hF, 32'h0000_0000, 32'h0000_0000, 1'b0};
      vecs[12] = '{2'd1, 1'b0, 4'hF, 32'h0000_0000, 32'h1234_5678, 1'b0};
      vecs[13] = '{2'd0, 1'b1, 4'hF, 32'h0000_0000, 32'h0000_0006, 1'b0};
      vecs[14] = '{2'd0, 1'b0, 4'hF, 32'h0000_0000, 32'h0000_0000, 1'b0};
      vecs[15] = '{2'd1, 1'b1, 4'hF, 32'hAABB_CCDD, 32'h1234_5678, 1'b0};
      vecs[16] = '{2'd1, 1'b1, 4'h4, 32'h1122_3344, 32'hAABB_CCDD, 1'b0};
      vecs[17] = '{2'd1, 1'b0, 4'hF, 32'h0000_0000, be_exp,        1'b0};

      do_reset();

      for (int i = 0; i < 18; i++) begin
         bus.addr  = vecs[i].addr;
         bus.we    = vecs[i].we;
         bus.be    = vecs[i].be;
         bus.wdata = vecs[i].wdata;
         exp_q.push_back(vecs[i].exp_rd);
         exp_q.push_back({31'd0, vecs[i].exp_irq});
         #1;
         compare($sformatf("vec%0d rdata", i), bus.rdata);
         compare($sformatf("vec%0d irq", i), {31'd0, bus.irq});
         tick();
      end
      bus.we = 1'b0;
      bus.be = 4'hF;

      // One-shot from PRESET=5 with interrupt enabled
      do_reset();
      wr(2'd1, 32'd5, 4'hF);
      wr(2'd0, 32'h9, 4'hF);
      check_rd(2'd2, 32'd0, "os idle count");
      tick();
      check_rd(2'd2, 32'd0, "os load count");
      for (int k = 0; k < 5; k++) begin
         tick();
         check_rd(2'd2, 32'd5 - k, $sformatf("os count step%0d", k));
         check_irq(1'b0, $sformatf("os irq step%0d", k));
      end
      tick();
      check_rd(2'd2, 32'd0, "os int count");
      check_irq(1'b0, "os irq in int");
      tick();
      check_irq(1'b1, "os irq after int");
      check_rd(2'd0, 32'h8, "os en cleared");
      check_rd(2'd2, 32'd0, "os count after int");
      for (int k = 0; k < 3; k++) begin
         tick();
         check_irq(1'b1, $sformatf("os irq held%0d", k));
      end
      wr(2'd0, 32'h0, 4'hF);
      check_irq(1'b0, "os irq cleared by ctrl write");
      check_rd(2'd0, 32'h0, "os ctrl after clear");

      // Auto-reload from PRESET=3: 5-cycle period
      do_reset();
      wr(2'd1, 32'd3, 4'hF);
      wr(2'd0, 32'hB, 4'hF);
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (k == 1) begin
            exp_cnt = 32'd0;
         end else begin
            ph = (k - 2) % 5;
            case (ph)
               0:       exp_cnt = 32'd3;
               1:       exp_cnt = 32'd2;
               2:       exp_cnt = 32'd1;
               default: exp_cnt = 32'd0;
            endcase
         end
         check_rd(2'd2, exp_cnt, $sformatf("ar count c%0d", k));
         check_irq((k >= 6) && ((k - 6) % 5 == 0), $sformatf("ar irq c%0d", k));
      end
      check_rd(2'd0, 32'hB, "ar en kept");
      wr(2'd0, 32'h0, 4'hF);

      // PRESET=0: no underflow wrap
      do_reset();
      wr(2'd1, 32'd0, 4'hF);
      wr(2'd0, 32'h9, 4'hF);
      tick();
      check_rd(2'd2, 32'd0, "p0 load count");
      tick();
      check_rd(2'd2, 32'd0, "p0 cnt count");
      tick();
      check_rd(2'd2, 32'd0, "p0 int count");
      check_irq(1'b0, "p0 irq in int");
      tick();
      check_irq(1'b1, "p0 irq after int");
      check_rd(2'd2, 32'd0, "p0 count no wrap");
      check_rd(2'd0, 32'h8, "p0 en cleared");

      // CPU write to CTRL in one-shot INT wins over the EN clear
      do_reset();
      wr(2'd1, 32'd2, 4'hF);
      wr(2'd0, 32'h9, 4'hF);
      tick();
      tick();
      tick();
      tick();
      check_rd(2'd2, 32'd0, "race int count");
      wr(2'd0, 32'h9, 4'hF);
      check_rd(2'd0, 32'h9, "race ctrl kept en");
      check_irq(1'b1, "race irq set");
      tick();
      check_irq(1'b1, "race irq in load");
      tick();
      check_rd(2'd2, 32'd2, "race new count");
      check_irq(1'b1, "race irq still held");

      // EN cleared during LOAD: load completes, then idle with frozen count
      do_reset();
      wr(2'd1, 32'd4, 4'hF);
      wr(2'd0, 32'h1, 4'hF);
      tick();
      wr(2'd0, 32'h0, 4'hF);
      check_rd(2'd2, 32'd4, "ld-stop loaded");
      tick();
      check_rd(2'd2, 32'd4, "ld-stop frozen1");
      tick();
      check_rd(2'd2, 32'd4, "ld-stop frozen2");
      check_irq(1'b0, "ld-stop irq");

      // PRESET and MODE changes mid-count apply at the next LOAD/INT; IM masks irq
      do_reset();
      wr(2'd1, 32'd3, 4'hF);
      wr(2'd0, 32'h1, 4'hF);
      tick();
      tick();
      check_rd(2'd2, 32'd3, "mid first count");
      wr(2'd1, 32'd2, 4'hF);
      check_rd(2'd2, 32'd2, "mid count unaffected");
      check_rd(2'd1, 32'd2, "mid preset written");
      wr(2'd0, 32'h3, 4'hF);
      check_rd(2'd2, 32'd1, "mid count after mode");
      tick();
      check_rd(2'd2, 32'd0, "mid int count");
      tick();
      check_rd(2'd0, 32'h3, "mid reload kept en");
      check_irq(1'b0, "mid irq masked");
      tick();
      check_rd(2'd2, 32'd2, "mid new preset loaded");

      // Reset mid-count, overriding a same-cycle PRESET write
      do_reset();
      wr(2'd1, 32'd100, 4'hF);
      wr(2'd0, 32'h9, 4'hF);
      tick();
      tick();
      tick();
      check_rd(2'd2, 32'd99, "rst count 99");
      wr(2'd1, 32'd7, 4'hF);
      check_rd(2'd2, 32'd98, "rst count kept");
      check_rd(2'd1, 32'd7, "rst preset 7");
      tick();
      check_rd(2'd2, 32'd97, "rst count 97");
      reset     = 1'b0;
      bus.addr  = 2'd1;
      bus.wdata = 32'hFFFF_FFFF;
      bus.we    = 1'b1;
      tick();
      bus.we    = 1'b0;
      reset     = 1'b1;
      check_rd(2'd0, 32'd0, "rst ctrl");
      check_rd(2'd1, 32'd0, "rst preset");
      check_rd(2'd2, 32'd0, "rst count");
      check_irq(1'b0, "rst irq");
      for (int k = 0; k < 8; k++) begin
         tick();
         check_rd(2'd2, 32'd0, $sformatf("rst idle count%0d", k));
         check_irq(1'b0, $sformatf("rst idle irq%0d", k));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
